pc_sequencer: RTL and testbench

- Multicycle control FSM that owns the PC-update path. It generates the PC-source select, the PC write strobes and the EPC write strobe, and sequences instruction fetch, branch/jump resolution and exception entry/return.
- Sits beside the PC-source mux and the PC/EPC registers and drives their control inputs.
- Opcode, funct and ALU flags come from the datapath. Memory has a fixed read latency.

---
 rtl/pc_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Multicycle control FSM for PC/EPC update, fetch and exception entry.
// Revision : 1.0  initial release
// ============================================================================
module pc_sequencer #(
    parameter int MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    input  logic       div_zero,
    output logic [2:0] pc_source,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       epc_write,
    output logic       mem_read,
    output logic       ir_write,
    output logic [7:0] exc_vector,
    output logic       exc_active,
    output logic       instr_done
);

    localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MEM_WAIT - 1);

    localparam logic [2:0] c_fetch    = 3'd0;
    localparam logic [2:0] c_decode   = 3'd1;
    localparam logic [2:0] c_exec     = 3'd2;
    localparam logic [2:0] c_wb       = 3'd3;
    localparam logic [2:0] c_exc_save = 3'd4;
    localparam logic [2:0] c_exc_load = 3'd5;
    localparam logic [2:0] c_exc_jump = 3'd6;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_rte   = 6'h10;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    localparam logic [5:0] c_fn_add = 6'h20;
    localparam logic [5:0] c_fn_sub = 6'h22;
    localparam logic [5:0] c_fn_div = 6'h1A;
    localparam logic [5:0] c_fn_jr  = 6'h08;

    localparam logic [7:0] c_vec_inv = 8'hFD;
    localparam logic [7:0] c_vec_ovf = 8'hFE;
    localparam logic [7:0] c_vec_dz  = 8'hFF;

    logic [2:0]       r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt, w_next_cnt;
    logic [7:0]       r_cause, w_next_cause;

    logic w_rtype, w_funct_ok, w_op_valid, w_is_arith, w_is_div, w_is_jr;
    logic w_cnt_done;

    logic [2:0] w_pc_source;
    logic       w_pc_write, w_pc_write_cond, w_epc_write, w_mem_read;
    logic       w_ir_write, w_exc_active, w_instr_done;

    assign w_rtype    = (opcode == c_op_rtype);
    assign w_funct_ok = (funct == c_fn_add) || (funct == c_fn_sub) ||
                        (funct == c_fn_div) || (funct == c_fn_jr);
    assign w_op_valid = (w_rtype && w_funct_ok) ||
                        (opcode == c_op_j)    || (opcode == c_op_jal) ||
                        (opcode == c_op_beq)  || (opcode == c_op_bne) ||
                        (opcode == c_op_addi) || (opcode == c_op_lw)  ||
                        (opcode == c_op_sw)   || (opcode == c_op_rte);
    assign w_is_arith = (w_rtype && ((funct == c_fn_add) || (funct == c_fn_sub))) ||
                        (opcode == c_op_addi);
    assign w_is_div   = w_rtype && (funct == c_fn_div);
    assign w_is_jr    = w_rtype && (funct == c_fn_jr);
    assign w_cnt_done = (r_cnt == c_cnt_last);

    always_comb begin
        w_next_state    = r_state;
        w_next_cnt      = r_cnt;
        w_next_cause    = r_cause;
        w_pc_source     = 3'b000;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_epc_write     = 1'b0;
        w_mem_read      = 1'b0;
        w_ir_write      = 1'b0;
        w_exc_active    = 1'b0;
        w_instr_done    = 1'b0;
        case (r_state)
            c_fetch: begin
                w_mem_read = 1'b1;
                if (w_cnt_done) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_next_cnt   = '0;
                    w_next_state = c_decode;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            c_decode: begin
                if (w_op_valid) begin
                    w_next_state = c_exec;
                end else begin
                    w_next_cause = c_vec_inv;
                    w_next_state = c_exc_save;
                end
            end
            c_exec: begin
                if ((opcode == c_op_beq) || (opcode == c_op_bne)) begin
                    // Strobe and select only when taken so the PC is untouched otherwise.
                    if (zero == (opcode == c_op_beq)) begin
                        w_pc_source     = 3'b001;
                        w_pc_write_cond = 1'b1;
                    end
                    w_instr_done = 1'b1;
                    w_next_state = c_fetch;
                end else if ((opcode == c_op_j) || (opcode == c_op_jal)) begin
                    w_pc_source  = 3'b010;
                    w_pc_write   = 1'b1;
                    w_instr_done = 1'b1;
                    w_next_state = c_fetch;
                end else if (w_is_jr) begin
                    w_pc_write   = 1'b1;
                    w_instr_done = 1'b1;
                    w_next_state = c_fetch;
                end else if (opcode == c_op_rte) begin
                    w_pc_source  = 3'b100;
                    w_pc_write   = 1'b1;
                    w_instr_done = 1'b1;
                    w_next_state = c_fetch;
                end else if (w_is_div && div_zero) begin
                    w_next_cause = c_vec_dz;
                    w_next_state = c_exc_save;
                end else if (w_is_arith && overflow) begin
                    w_next_cause = c_vec_ovf;
                    w_next_state = c_exc_save;
                end else begin
                    w_next_state = c_wb;
                end
            end
            c_wb: begin
                if (opcode == c_op_lw) begin
                    w_mem_read = 1'b1;
                    if (w_cnt_done) begin
                        w_instr_done = 1'b1;
                        w_next_cnt   = '0;
                        w_next_state = c_fetch;
                    end else begin
                        w_next_cnt = r_cnt + 1'b1;
                    end
                end else begin
                    w_instr_done = 1'b1;
                    w_next_state = c_fetch;
                end
            end
            c_exc_save: begin
                w_epc_write  = 1'b1;
                w_exc_active = 1'b1;
                w_next_state = c_exc_load;
            end
            c_exc_load: begin
                w_mem_read   = 1'b1;
                w_exc_active = 1'b1;
                if (w_cnt_done) begin
                    w_next_cnt   = '0;
                    w_next_state = c_exc_jump;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            c_exc_jump: begin
                w_pc_source  = 3'b110;
                w_pc_write   = 1'b1;
                w_exc_active = 1'b1;
                w_instr_done = 1'b1;
                w_next_cause = 8'h00;
                w_next_state = c_fetch;
            end
            default: begin
                w_next_cnt   = '0;
                w_next_cause = 8'h00;
                w_next_state = c_fetch;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_fetch;
            r_cnt   <= '0;
            r_cause <= 8'h00;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_cause <= w_next_cause;
        end
    end

    // Outputs are forced quiet while reset is held, even though the state is already FETCH.
    assign pc_source     = reset ? 3'b000 : w_pc_source;
    assign pc_write      = ~reset & w_pc_write;
    assign pc_write_cond = ~reset & w_pc_write_cond;
    assign epc_write     = ~reset & w_epc_write;
    assign mem_read      = ~reset & w_mem_read;
    assign ir_write      = ~reset & w_ir_write;
    assign exc_active    = ~reset & w_exc_active;
    assign instr_done    = ~reset & w_instr_done;
    assign exc_vector    = (~reset & w_exc_active) ? r_cause : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed self-checking bench for pc_sequencer (MEM_WAIT = 2).
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;
    logic       div_zero;
    logic [2:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       epc_write;
    logic       mem_read;
    logic       ir_write;
    logic [7:0] exc_vector;
    logic       exc_active;
    logic       instr_done;

    int n_checks = 0;
    int n_pass   = 0;
    bit fresh    = 1'b0;

    logic [17:0] exp_q[$];

    pc_sequencer #(.MEM_WAIT(2)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .overflow      (overflow),
        .div_zero      (div_zero),
        .pc_source     (pc_source),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .epc_write     (epc_write),
        .mem_read      (mem_read),
        .ir_write      (ir_write),
        .exc_vector    (exc_vector),
        .exc_active    (exc_active),
        .instr_done    (instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // {pc_source, pc_write, pc_write_cond, epc_write, mem_read, ir_write, exc_active, instr_done, exc_vector}
    function automatic logic [17:0] pk(input logic [2:0] src, input logic pw, input logic pwc,
                                       input logic epc, input logic mr, input logic ir,
                                       input logic ea, input logic dn, input logic [7:0] vec);
        return {src, pw, pwc, epc, mr, ir, ea, dn, vec};
    endfunction

    function automatic logic [17:0] observed();
        return {pc_source, pc_write, pc_write_cond, epc_write, mem_read, ir_write,
                exc_active, instr_done, exc_vector};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One instruction: inputs applied in the first FETCH cycle, then one check per cycle.
    task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic ov, input logic dz);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0 || !fresh) @(posedge clk);
            #1;
            if (i == 0) begin
                opcode = op; funct = fn; zero = z; overflow = ov; div_zero = dz;
                fresh  = 1'b0;
            end
            #1;
            check($sformatf("%s[%0d]", tag, i), 32'(observed()), 32'(exp_q[i]));
        end
    endtask

    logic [17:0] c_f0, c_f1, c_z, c_dn, c_mr;

    initial begin
        c_f0 = pk(3'b000, 0, 0, 0, 1, 0, 0, 0, 8'h00);
        c_f1 = pk(3'b000, 1, 0, 0, 1, 1, 0, 0, 8'h00);
        c_z  = pk(3'b000, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        c_dn = pk(3'b000, 0, 0, 0, 0, 0, 0, 1, 8'h00);
        c_mr = pk(3'b000, 0, 0, 0, 1, 0, 0, 0, 8'h00);

        reset = 1'b1; opcode = 6'h00; funct = 6'h20;
        zero = 1'b0; overflow = 1'b0; div_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'(observed()), 32'(c_z));
        reset = 1'b0;
        fresh = 1'b1;

        exp_q = '{c_f0, c_f1, c_z, c_z, c_dn};
        run("add", 6'h00, 6'h20, 0, 0, 0);

        exp_q = '{c_f0, c_f1, c_z, pk(3'b001, 0, 1, 0, 0, 0, 0, 1, 8'h00)};
        run("beq_taken", 6'h04, 6'h00, 1, 0, 0);

        exp_q = '{c_f0, c_f1, c_z, c_dn};
        run("beq_not_taken", 6'h04, 6'h00, 0, 0, 0);

        exp_q = '{c_f0, c_f1, c_z, pk(3'b001, 0, 1, 0, 0, 0, 0, 1, 8'h00)};
        run("bne_taken", 6'h05, 6'h00, 0, 0, 0);

        exp_q = '{c_f0, c_f1, c_z, pk(3'b010, 1, 0, 0, 0, 0, 0, 1, 8'h00)};
        run("j", 6'h02, 6'h00, 0, 0, 0);

        exp_q = '{c_f0, c_f1, c_z, pk(3'b100, 1, 0, 0, 0, 0, 0, 1, 8'h00)};
        run("rte", 6'h10, 6'h00, 0, 0, 0);

        exp_q = '{c_f0, c_f1, c_z, pk(3'b000, 1, 0, 0, 0, 0, 0, 1, 8'h00)};
        run("jr", 6'h00, 6'h08, 0, 0, 0);

        exp_q = '{c_f0, c_f1, c_z, c_z, c_mr, pk(3'b000, 0, 0, 0, 1, 0, 0, 1, 8'h00)};
        run("lw", 6'h23, 6'h00, 0, 0, 0);

        exp_q = '{c_f0, c_f1, c_z,
                  pk(3'b000, 0, 0, 1, 0, 0, 1, 0, 8'hFD),
                  pk(3'b000, 0, 0, 0, 1, 0, 1, 0, 8'hFD),
                  pk(3'b000, 0, 0, 0, 1, 0, 1, 0, 8'hFD),
                  pk(3'b110, 1, 0, 0, 0, 0, 1, 1, 8'hFD)};
        run("bad_opcode", 6'h3F, 6'h00, 0, 0, 0);

        exp_q = '{c_f0, c_f1, c_z,
                  pk(3'b000, 0, 0, 1, 0, 0, 1, 0, 8'hFD),
                  pk(3'b000, 0, 0, 0, 1, 0, 1, 0, 8'hFD),
                  pk(3'b000, 0, 0, 0, 1, 0, 1, 0, 8'hFD),
                  pk(3'b110, 1, 0, 0, 0, 0, 1, 1, 8'hFD)};
        run("bad_funct", 6'h00, 6'h21, 0, 0, 0);

        exp_q = '{c_f0, c_f1, c_z, c_z,
                  pk(3'b000, 0, 0, 1, 0, 0, 1, 0, 8'hFF),
                  pk(3'b000, 0, 0, 0, 1, 0, 1, 0, 8'hFF),
                  pk(3'b000, 0, 0, 0, 1, 0, 1, 0, 8'hFF),
                  pk(3'b110, 1, 0, 0, 0, 0, 1, 1, 8'hFF)};
        run("div_zero", 6'h00, 6'h1A, 0, 1, 1);

        exp_q = '{c_f0, c_f1, c_z, c_z,
                  pk(3'b000, 0, 0, 1, 0, 0, 1, 0, 8'hFE),
                  pk(3'b000, 0, 0, 0, 1, 0, 1, 0, 8'hFE),
                  pk(3'b000, 0, 0, 0, 1, 0, 1, 0, 8'hFE),
                  pk(3'b110, 1, 0, 0, 0, 0, 1, 1, 8'hFE)};
        run("add_ovf", 6'h00, 6'h20, 0, 1, 0);

        // sub ignores div_zero; addi with no overflow completes normally
        exp_q = '{c_f0, c_f1, c_z, c_z, c_dn};
        run("sub_ignore_dz", 6'h00, 6'h22, 0, 0, 1);

        exp_q = '{c_f0, c_f1, c_z, c_z, c_dn};
        run("addi", 6'h08, 6'h00, 0, 0, 0);

        // addi overflow, then reset hits in the first EXC_LOAD cycle
        exp_q = '{c_f0, c_f1, c_z, c_z,
                  pk(3'b000, 0, 0, 1, 0, 0, 1, 0, 8'hFE),
                  pk(3'b000, 0, 0, 0, 1, 0, 1, 0, 8'hFE)};
        run("addi_ovf_pre", 6'h08, 6'h00, 0, 1, 0);
        reset = 1'b1;
        #1;
        check("reset_mid_exc", 32'(observed()), 32'(c_z));
        @(posedge clk);
        #1;
        check("reset_held", 32'(observed()), 32'(c_z));
        reset = 1'b0;
        fresh = 1'b1;

        exp_q = '{c_f0, c_f1, c_z, c_z, c_dn};
        run("add_after_reset", 6'h00, 6'h20, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
